// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-register widths, field offsets and stage states
package pipe_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int CTRL_FIELD_W = 5;

    // EX/MEM bundle, MSB first: ctrl | addr | wdata | alu | pc4 | waddr
    localparam int EX_MEM_WADDR_OFF = 0;
    localparam int EX_MEM_PC4_OFF   = EX_MEM_WADDR_OFF + REG_ADDR_W;
    localparam int EX_MEM_ALU_OFF   = EX_MEM_PC4_OFF + XLEN;
    localparam int EX_MEM_WDATA_OFF = EX_MEM_ALU_OFF + XLEN;
    localparam int EX_MEM_ADDR_OFF  = EX_MEM_WDATA_OFF + XLEN;
    localparam int EX_MEM_CTRL_OFF  = EX_MEM_ADDR_OFF + XLEN;
    localparam int EX_MEM_W         = EX_MEM_CTRL_OFF + CTRL_FIELD_W;

    // Default bundle widths for the other stage boundaries
    localparam int IF_ID_W  = CTRL_FIELD_W + 2 * XLEN;
    localparam int ID_EX_W  = CTRL_FIELD_W + 4 * XLEN + REG_ADDR_W;
    localparam int MEM_WB_W = CTRL_FIELD_W + 2 * XLEN + REG_ADDR_W;

    // Encoding doubles as the number of entries held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] state_occupancy(state_t s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid-tagged bundle register with ctrl zeroing on clear
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_W,
    parameter int CTRL_W = CTRL_FIELD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    // Clear wins over load; only the ctrl field is zeroed so bubble payload bits hold still
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid                 <= 1'b0;
            q[DATA_W-1 -: CTRL_W] <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - elastic valid/ready pipeline stage with skid, flush and stall counter
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_W,
    parameter int CTRL_W = CTRL_FIELD_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              push;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_d;
    logic              main_valid;
    logic [DATA_W-1:0] main_q;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_q;

    // A push offered during flush is dropped; a pop during flush still completes downstream
    assign pop  = main_valid & out_ready;
    assign push = in_valid & in_ready & ~flush;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_data),
                .valid (skid_valid),
                .q     (skid_q)
            );
            // Ready comes straight from a flop, breaking the out_ready -> in_ready path
            assign in_ready = ~skid_valid;
        end else begin : g_single
            assign skid_valid = 1'b0;
            assign skid_q     = '0;
            // Single register: accept when empty or when the held entry leaves this cycle
            assign in_ready   = out_ready | ~main_valid;
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: occupancy tracking, flush returns to EMPTY unconditionally
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (push) state_nxt = ST_BUSY;
                ST_BUSY: begin
                    if (push && !pop && SKID != 0) state_nxt = ST_FULL;
                    else if (!push && pop)         state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_nxt = ST_BUSY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: MAIN always presents the oldest entry, SKID absorbs one overflow
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_data;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = push;
                ST_BUSY: begin
                    if (push && pop) main_load  = 1'b1;
                    else if (push)   skid_load  = 1'b1;
                    else if (pop)    main_clear = 1'b1;
                end
                ST_FULL: begin
                    if (pop) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles the downstream refused a presented bundle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - self-checking bench for pipe_stage_hs against a FIFO reference model
module tb_pipe_stage_hs;

    localparam int W  = 138;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           fl   [3];
    logic           iv   [3];
    logic           ordy [3];
    logic [W-1:0]   id   [3];
    logic           ir   [3];
    logic           ov   [3];
    logic [W-1:0]   od   [3];
    logic [1:0]     oc   [3];
    logic [15:0]    sc0;
    logic [15:0]    sc1;
    logic [3:0]     sc2;

    int checks = 0;
    int errors = 0;

    // Reference: each stage is a FIFO of capacity 1 or 2 plus a saturating stall tally
    logic [W-1:0]   mdat [3][2];
    int             mcnt [3];
    int             mstall [3];
    int             skid_cfg [3]  = '{1, 0, 1};
    int             stall_max [3] = '{65535, 65535, 15};

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(W), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(oc[0]), .stall_cnt(sc0));

    pipe_stage_hs #(.DATA_W(W), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(oc[1]), .stall_cnt(sc1));

    pipe_stage_hs #(.DATA_W(W), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset(rst_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .occupancy(oc[2]), .stall_cnt(sc2));

    function automatic logic [15:0] stall_of(int d);
        case (d)
            0:       return sc0;
            1:       return sc1;
            default: return {12'd0, sc2};
        endcase
    endfunction

    function automatic logic exp_ir(int d);
        if (skid_cfg[d] != 0) return (mcnt[d] < 2);
        return (mcnt[d] == 0) || (ordy[d] == 1'b1);
    endfunction

    function automatic logic exp_ov(int d);
        return (mcnt[d] > 0);
    endfunction

    // Apply this cycle's transfers to the model of every stage, just before the rising edge
    task automatic tick();
        for (int d = 0; d < 3; d++) begin
            logic push;
            logic pop;
            push = iv[d] && exp_ir(d) && !fl[d];
            pop  = exp_ov(d) && ordy[d];
            if (exp_ov(d) && !ordy[d] && mstall[d] < stall_max[d]) mstall[d]++;
            if (fl[d]) begin
                mcnt[d] = 0;
            end else begin
                if (pop) begin
                    mdat[d][0] = mdat[d][1];
                    mcnt[d]--;
                end
                if (push) begin
                    mdat[d][mcnt[d]] = id[d];
                    mcnt[d]++;
                end
            end
        end
    endtask

    task automatic drive(int d, logic v, logic [W-1:0] x, logic rdy, logic f);
        @(negedge clk);
        iv[d]   = v;
        id[d]   = x;
        ordy[d] = rdy;
        fl[d]   = f;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b1; id[d] = '1; ordy[d] = 1'b0; fl[d] = 1'b0;
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; mcnt[d] = 0; mstall[d] = 0;
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", d, ov[d]); end
            checks++; if (oc[d] !== 2'd0) begin errors++; $display("FAIL reset_occupancy dut%0d: got %0d expected 0", d, oc[d]); end
            checks++; if (ir[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, ir[d]); end
            checks++; if (stall_of(d) !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt dut%0d: got %0d expected 0", d, stall_of(d)); end
            checks++; if (od[d] !== '0) begin errors++; $display("FAIL reset_out_data dut%0d: got %0h expected 0", d, od[d]); end
        end
        tick();
    endtask

    task automatic test_streaming(int d);
        for (int k = 0; k <= 32; k++) begin
            drive(d, (k < 32), W'(k + 1), 1'b1, 1'b0);
            checks++; if (ir[d] !== 1'b1) begin errors++; $display("FAIL stream_in_ready dut%0d k=%0d: got %b expected 1", d, k, ir[d]); end
            if (k == 0) begin
                checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL stream_first_valid dut%0d: got %b expected 0", d, ov[d]); end
            end else begin
                checks++; if (ov[d] !== 1'b1) begin errors++; $display("FAIL stream_gap dut%0d k=%0d: got %b expected 1", d, k, ov[d]); end
                checks++; if (od[d] !== W'(k)) begin errors++; $display("FAIL stream_data dut%0d k=%0d: got %0h expected %0h", d, k, od[d], k); end
                checks++; if (oc[d] !== 2'd1) begin errors++; $display("FAIL stream_occ dut%0d k=%0d: got %0d expected 1", d, k, oc[d]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, c;
        int s0;
        a = {5'h11, 133'hA0A};
        b = {5'h12, 133'hB0B};
        c = {5'h13, 133'hC0C};
        drive(0, 1'b1, a, 1'b1, 1'b0);
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_c0_valid: got %b expected 0", ov[0]); end
        s0 = mstall[0];
        tick();
        drive(0, 1'b1, b, 1'b0, 1'b0);
        checks++; if (od[0] !== a || ov[0] !== 1'b1) begin errors++; $display("FAIL bp_c1_data: got %0h/%b expected %0h/1", od[0], ov[0], a); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp_c1_ready: got %b expected 1", ir[0]); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, c, 1'b0, 1'b0);
            checks++; if (oc[0] !== 2'd2) begin errors++; $display("FAIL bp_full_occ k=%0d: got %0d expected 2", k, oc[0]); end
            checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_full_ready k=%0d: got %b expected 0", k, ir[0]); end
            checks++; if (od[0] !== a) begin errors++; $display("FAIL bp_hold_data k=%0d: got %0h expected %0h", k, od[0], a); end
            tick();
        end
        drive(0, 1'b1, c, 1'b1, 1'b0);
        checks++; if (od[0] !== a || ir[0] !== 1'b0) begin errors++; $display("FAIL bp_release_a: got %0h/%b expected %0h/0", od[0], ir[0], a); end
        tick();
        drive(0, 1'b1, c, 1'b1, 1'b0);
        checks++; if (od[0] !== b || oc[0] !== 2'd1 || ir[0] !== 1'b1) begin errors++; $display("FAIL bp_release_b: got %0h occ %0d rdy %b expected %0h occ 1 rdy 1", od[0], oc[0], ir[0], b); end
        tick();
        drive(0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (od[0] !== c || ov[0] !== 1'b1) begin errors++; $display("FAIL bp_release_c: got %0h/%b expected %0h/1", od[0], ov[0], c); end
        checks++; if (stall_of(0) !== 16'(s0 + 4)) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_of(0), s0 + 4); end
        tick();
        drive(0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (ov[0] !== 1'b0 || oc[0] !== 2'd0) begin errors++; $display("FAIL bp_drained: got %b occ %0d expected 0 occ 0", ov[0], oc[0]); end
        tick();
    endtask

    task automatic test_flush();
        logic [W-1:0] a, b, c;
        a = {5'h1F, 133'h111};
        b = {5'h1E, 133'h222};
        c = {5'h1D, 133'h333};
        drive(0, 1'b1, a, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, b, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, c, 1'b0, 1'b1);
        checks++; if (oc[0] !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 2", oc[0]); end
        tick();
        drive(0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ov[0]); end
        checks++; if (od[0][W-1 -: CW] !== '0) begin errors++; $display("FAIL flush_ctrl: got %0h expected 0", od[0][W-1 -: CW]); end
        checks++; if (oc[0] !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", oc[0]); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", ir[0]); end
        checks++; if (stall_of(0) !== 16'(mstall[0])) begin errors++; $display("FAIL flush_stall: got %0d expected %0d", stall_of(0), mstall[0]); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, '0, 1'b1, 1'b0);
            checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_ghost k=%0d: got %b data %0h expected 0", k, ov[0], od[0]); end
            tick();
        end
    endtask

    task automatic test_saturation();
        drive(2, 1'b1, {5'h07, 133'h5A5}, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 24; k++) begin
            int e;
            drive(2, 1'b0, '0, 1'b0, 1'b0);
            e = (k - 1 > 15) ? 15 : k - 1;
            checks++; if (stall_of(2) !== 16'(e)) begin errors++; $display("FAIL sat_stall k=%0d: got %0d expected %0d", k, stall_of(2), e); end
            tick();
        end
        drive(2, 1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(2, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (stall_of(2) !== 16'd15 || ov[2] !== 1'b0) begin errors++; $display("FAIL sat_after_flush: got %0d/%b expected 15/0", stall_of(2), ov[2]); end
        tick();
    endtask

    task automatic test_skid0_comb();
        logic [W-1:0] x, y;
        x = {5'h0C, 133'hCAFE};
        y = {5'h0D, 133'hBEEF};
        drive(1, 1'b1, x, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, y, 1'b0, 1'b0);
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL skid0_blocked: got %b expected 0", ir[1]); end
        ordy[1] = 1'b1;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL skid0_comb_ready: got %b expected 1", ir[1]); end
        tick();
        drive(1, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (od[1] !== y || oc[1] !== 2'd1) begin errors++; $display("FAIL skid0_replace: got %0h occ %0d expected %0h occ 1", od[1], oc[1], y); end
        tick();
    endtask

    task automatic test_random(int d, int n);
        for (int k = 0; k < n; k++) begin
            logic [159:0] r;
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(d, ($urandom_range(0, 3) != 0), r[W-1:0], ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0));
            checks++; if (ir[d] !== exp_ir(d)) begin errors++; $display("FAIL rand_in_ready dut%0d k=%0d: got %b expected %b", d, k, ir[d], exp_ir(d)); end
            checks++; if (ov[d] !== exp_ov(d)) begin errors++; $display("FAIL rand_out_valid dut%0d k=%0d: got %b expected %b", d, k, ov[d], exp_ov(d)); end
            checks++; if (oc[d] !== 2'(mcnt[d])) begin errors++; $display("FAIL rand_occ dut%0d k=%0d: got %0d expected %0d", d, k, oc[d], mcnt[d]); end
            if (exp_ov(d)) begin
                checks++; if (od[d] !== mdat[d][0]) begin errors++; $display("FAIL rand_data dut%0d k=%0d: got %0h expected %0h", d, k, od[d], mdat[d][0]); end
            end else begin
                checks++; if (od[d][W-1 -: CW] !== '0) begin errors++; $display("FAIL rand_bubble_ctrl dut%0d k=%0d: got %0h expected 0", d, k, od[d][W-1 -: CW]); end
            end
            checks++; if (stall_of(d) !== 16'(mstall[d])) begin errors++; $display("FAIL rand_stall dut%0d k=%0d: got %0d expected %0d", d, k, stall_of(d), mstall[d]); end
            tick();
        end
        drive(d, 1'b0, '0, 1'b1, 1'b1);
        tick();
        fl[d] = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, {5'h09, 133'h99}, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, {5'h0A, 133'hAA}, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        checks++; if (oc[0] !== 2'd2) begin errors++; $display("FAIL midrst_pre_occ: got %0d expected 2", oc[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (ov[0] !== 1'b0 || oc[0] !== 2'd0) begin errors++; $display("FAIL midrst_cleared: got %b occ %0d expected 0 occ 0", ov[0], oc[0]); end
        checks++; if (od[0] !== '0) begin errors++; $display("FAIL midrst_data: got %0h expected 0", od[0]); end
        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0; mstall[d] = 0; iv[d] = 1'b0; fl[d] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ir[0] !== 1'b1 || stall_of(0) !== 16'd0) begin errors++; $display("FAIL midrst_release: got rdy %b stall %0d expected 1/0", ir[0], stall_of(0)); end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_streaming(0);
        test_backpressure();
        test_flush();
        test_saturation();
        test_streaming(1);
        test_skid0_comb();
        test_random(0, 300);
        test_random(1, 300);
        test_random(2, 300);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
